fighter_motion: RTL

//  Per-player fighter movement/action controller; parametrised successor to the single-ball motion block.

---
 rtl/fighter_motion_if.sv | 23 ++
 rtl/fighter_motion.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fighter_motion_if.sv
// Keycode/video-sync inputs and sprite outputs for one fighter_motion instance.
// The DUT takes the slave modport; the keycode PIO / colour-mapper side takes master.
interface fighter_motion_if #(
  parameter int unsigned NKEYS = 2
);
  logic                 frame_vs;
  logic [8*NKEYS-1:0]   keycode;
  logic [9:0]           FighterX;
  logic [9:0]           FighterY;
  logic                 facing;
  logic [1:0]           state;
  logic                 attack_active;

  modport master (
    output frame_vs, keycode,
    input  FighterX, FighterY, facing, state, attack_active
  );

  modport slave (
    input  frame_vs, keycode,
    output FighterX, FighterY, facing, state, attack_active
  );
endinterface

// File: rtl/fighter_motion.sv
// Per-player fighter controller: decodes held keycodes into walk/jump/attack and
// integrates sprite position once per video frame (rising edge of synchronised vsync).
module fighter_motion #(
  parameter int unsigned NKEYS      = 2,
  parameter int          X_MIN      = 0,
  parameter int          X_MAX      = 639,
  parameter int          W          = 64,
  parameter int          X_START    = 100,
  parameter int          GROUND_Y   = 380,
  parameter int          STEP       = 2,
  parameter int          JUMP_V     = 12,
  parameter int          GRAVITY    = 1,
  parameter int          ATK_FRAMES = 12,
  parameter logic [7:0]  KEY_LEFT   = 8'h04,
  parameter logic [7:0]  KEY_RIGHT  = 8'h07,
  parameter logic [7:0]  KEY_JUMP   = 8'h1A,
  parameter logic [7:0]  KEY_ATK    = 8'h14
) (
  input logic              Clk,
  input logic              Reset,
  fighter_motion_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StWalk   = 2'b01,
    StJump   = 2'b10,
    StAttack = 2'b11
  } state_e;

  localparam logic signed [10:0] XLo     = 11'(X_MIN);
  localparam logic signed [10:0] XHi     = 11'(X_MAX - W + 1);
  localparam logic signed [10:0] StepS   = 11'(STEP);
  localparam logic signed [11:0] GroundS = 12'(GROUND_Y);
  localparam logic signed [7:0]  JumpVy  = 8'(-JUMP_V);
  localparam logic signed [7:0]  GravS   = 8'(GRAVITY);
  localparam logic [7:0]         AtkInit = 8'(ATK_FRAMES - 1);

  logic [2:0]         sync_q;
  logic               tick;
  state_e             state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic signed [7:0]  vy_q, vy_d;
  logic signed [10:0] jump_dx_q, jump_dx_d;
  logic [7:0]         atk_cnt_q, atk_cnt_d;
  logic               facing_q, facing_d;
  logic               a_prev_q, a_prev_d;

  logic key_l, key_r, key_j, key_a, go_l, go_r;
  logic signed [11:0] y_n;

  function automatic logic [9:0] clamp_x(input logic signed [10:0] v);
    if (v < XLo) return 10'(XLo);
    if (v > XHi) return 10'(XHi);
    return v[9:0];
  endfunction

  // sync_q[1] is the synchronised vsync, sync_q[2] its previous value.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], bus.frame_vs};
  end
  assign tick = sync_q[1] & ~sync_q[2];

  always_comb begin
    key_l = 1'b0;
    key_r = 1'b0;
    key_j = 1'b0;
    key_a = 1'b0;
    for (int unsigned k = 0; k < NKEYS; k++) begin
      if (bus.keycode[8*k +: 8] == KEY_LEFT)  key_l = 1'b1;
      if (bus.keycode[8*k +: 8] == KEY_RIGHT) key_r = 1'b1;
      if (bus.keycode[8*k +: 8] == KEY_JUMP)  key_j = 1'b1;
      if (bus.keycode[8*k +: 8] == KEY_ATK)   key_a = 1'b1;
    end
  end

  // Opposing directions cancel out.
  assign go_l = key_l & ~key_r;
  assign go_r = key_r & ~key_l;
  assign y_n  = $signed({2'b00, y_q}) + $signed({{4{vy_q[7]}}, vy_q});

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    vy_d      = vy_q;
    jump_dx_d = jump_dx_q;
    atk_cnt_d = atk_cnt_q;
    facing_d  = facing_q;
    a_prev_d  = a_prev_q;
    if (tick) begin
      a_prev_d = key_a;
      unique case (state_q)
        StIdle, StWalk: begin
          if (key_a && !a_prev_q) begin
            state_d   = StAttack;
            atk_cnt_d = AtkInit;
          end else if (key_j) begin
            state_d   = StJump;
            vy_d      = JumpVy;
            jump_dx_d = go_l ? -StepS : (go_r ? StepS : '0);
          end else if (go_l) begin
            state_d  = StWalk;
            x_d      = clamp_x($signed({1'b0, x_q}) - StepS);
            facing_d = 1'b0;
          end else if (go_r) begin
            state_d  = StWalk;
            x_d      = clamp_x($signed({1'b0, x_q}) + StepS);
            facing_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
        StJump: begin
          x_d = clamp_x($signed({1'b0, x_q}) + jump_dx_q);
          if (y_n >= GroundS) begin
            y_d     = 10'(GROUND_Y);
            vy_d    = '0;
            state_d = StIdle;
          end else if (y_n < 0) begin
            y_d  = '0;
            vy_d = '0;
          end else begin
            y_d  = y_n[9:0];
            vy_d = vy_q + GravS;
          end
        end
        StAttack: begin
          if (atk_cnt_q == '0) state_d = StIdle;
          else                 atk_cnt_d = atk_cnt_q - 8'd1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      x_q       <= 10'(X_START);
      y_q       <= 10'(GROUND_Y);
      vy_q      <= '0;
      jump_dx_q <= '0;
      atk_cnt_q <= '0;
      facing_q  <= 1'b1;
      a_prev_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vy_q      <= vy_d;
      jump_dx_q <= jump_dx_d;
      atk_cnt_q <= atk_cnt_d;
      facing_q  <= facing_d;
      a_prev_q  <= a_prev_d;
    end
  end

  assign bus.FighterX      = x_q;
  assign bus.FighterY      = y_q;
  assign bus.facing        = facing_q;
  assign bus.state         = state_q;
  assign bus.attack_active = (state_q == StAttack);

endmodule
